// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Format codes 000-100 line up with the decoder's ImmSrc selector.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'b000,
    FMT_S    = 3'b001,
    FMT_B    = 3'b010,
    FMT_U    = 3'b011,
    FMT_J    = 3'b100,
    FMT_LI   = 3'b101,
    FMT_RSV6 = 3'b110,
    FMT_RSV7 = 3'b111
  } fmt_e;

  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic signed [31:0] I_MIN = -32'sd2048;
  localparam logic signed [31:0] I_MAX =  32'sd2047;
  localparam logic signed [31:0] B_MIN = -32'sd4096;
  localparam logic signed [31:0] B_MAX =  32'sd4094;
  localparam logic signed [31:0] J_MIN = -32'sd1048576;
  localparam logic signed [31:0] J_MAX =  32'sd1048574;

endpackage

// File: rtl/imm_field_pack.sv
// Combinational field packer: scatters the immediate into its instruction
// positions and flags immediates the chosen format cannot represent.
module imm_field_pack
  import instr_enc_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  logic signed [31:0] simm;
  assign simm = signed'(imm);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    instr = NOP_WORD;
    err   = 1'b1;
    case (fmt)
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = (simm < I_MIN) || (simm > I_MAX);
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = (simm < I_MIN) || (simm > I_MAX);
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = (simm < B_MIN) || (simm > B_MAX) || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = (simm < J_MIN) || (simm > J_MAX) || imm[0];
      end
      default: begin
        instr = NOP_WORD;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: registers one packed word per request, expanding
// li into lui/addi, with a valid/ready stream on both sides.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter bit LI_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  typedef enum logic [1:0] {EMPTY, HOLD, HOLD_FIRST} state_e;

  state_e      state;
  fmt_e        fmt;
  logic        li_mode, li_small, li_lo_zero, two_word, accept;
  logic [19:0] li_hi;

  fmt_e        m_fmt;
  logic [6:0]  m_opcode;
  logic [4:0]  m_rs1;
  logic [2:0]  m_funct3;
  logic [31:0] m_imm;
  logic [31:0] main_instr, second_instr, pending_instr;
  logic        main_err, second_err, pending_err;

  assign fmt        = fmt_e'(in_fmt);
  assign li_mode    = LI_ENABLE && (fmt == FMT_LI);
  assign li_small   = (signed'(in_imm) >= I_MIN) && (signed'(in_imm) <= I_MAX);
  assign li_lo_zero = (in_imm[11:0] == 12'd0);
  // (imm + 0x800) >> 12: bit 11 is exactly the carry out of the low 12 bits.
  assign li_hi      = in_imm[31:12] + {19'd0, in_imm[11]};
  assign two_word   = li_mode && !li_small && !li_lo_zero;

  assign in_ready = rst_n && ((state == EMPTY) || ((state == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    m_fmt    = fmt;
    m_opcode = in_opcode;
    m_rs1    = in_rs1;
    m_funct3 = in_funct3;
    m_imm    = in_imm;
    if (li_mode) begin
      if (li_small) begin
        m_fmt    = FMT_I;
        m_opcode = OP_IMM;
        m_rs1    = 5'd0;
        m_funct3 = 3'b000;
      end else begin
        m_fmt    = FMT_U;
        m_opcode = OP_LUI;
        m_imm    = {li_hi, 12'd0};
      end
    end
  end

  imm_field_pack u_pack_main (
    .fmt    (m_fmt),
    .opcode (m_opcode),
    .rd     (in_rd),
    .rs1    (m_rs1),
    .rs2    (in_rs2),
    .funct3 (m_funct3),
    .imm    (m_imm),
    .instr  (main_instr),
    .err    (main_err)
  );

  // Second li word: addi rd, rd, sext(imm[11:0]).
  imm_field_pack u_pack_second (
    .fmt    (FMT_I),
    .opcode (OP_IMM),
    .rd     (in_rd),
    .rs1    (in_rd),
    .rs2    (5'd0),
    .funct3 (3'b000),
    .imm    ({{20{in_imm[11]}}, in_imm[11:0]}),
    .instr  (second_instr),
    .err    (second_err)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= EMPTY;
      out_valid     <= 1'b0;
      out_instr     <= 32'd0;
      out_err       <= 1'b0;
      out_last      <= 1'b0;
      // NOTE: the pending word is a single register, so it is reset too; a
      // dropped second word can never leak out after reset.
      pending_instr <= 32'd0;
      pending_err   <= 1'b0;
    end else if (accept) begin
      state         <= two_word ? HOLD_FIRST : HOLD;
      out_valid     <= 1'b1;
      out_instr     <= main_instr;
      out_err       <= main_err && !li_mode;
      out_last      <= !two_word;
      pending_instr <= second_instr;
      pending_err   <= second_err;
    end else if (out_ready) begin
      case (state)
        HOLD_FIRST: begin
          state     <= HOLD;
          out_instr <= pending_instr;
          out_err   <= pending_err;
          out_last  <= 1'b1;
        end
        HOLD: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, then random
// round-trips through a decoder model and an li execution model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_err, out_last;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr;

  int n_checks = 0;
  int n_pass   = 0;

  instr_encoder #(.LI_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one request and return #1 after its handshake edge.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [31:0] imm);
    int waited = 0;
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = imm; in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Immediate as the core's decoder would reconstruct it.
  function automatic logic [31:0] dec_imm(input logic [2:0] f, input logic [31:0] w);
    case (f)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {w[31:12], 12'd0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  // Non-immediate bits of a word and the expected values of those bits.
  function automatic logic [31:0] field_mask(input logic [2:0] f);
    case (f)
      3'd0:       return 32'h000F_FFFF;
      3'd1, 3'd2: return 32'h01FF_F07F;
      default:    return 32'h0000_0FFF;
    endcase
  endfunction

  function automatic logic [31:0] exp_fields(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3);
    logic [31:0] w;
    w = {25'd0, op};
    if (f == 3'd0) w |= (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
    else if (f == 3'd1 || f == 3'd2) w |= (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
    else w |= 32'(rd) << 7;
    return w;
  endfunction

  function automatic logic exp_err(input logic [2:0] f, input int imm);
    case (f)
      3'd0, 3'd1: return (imm < -2048) || (imm > 2047);
      3'd2:       return (imm < -4096) || (imm > 4094) || ((imm & 1) != 0);
      3'd3:       return (imm & 32'hFFF) != 0;
      default:    return (imm < -1048576) || (imm > 1048574) || ((imm & 1) != 0);
    endcase
  endfunction

  logic [31:0] w_first, regv, src;
  int          words, r, imm;
  logic [4:0]  rd;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_imm = 32'd0;
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err",   32'(out_err), 32'd0);
    check("rst_out_last",  32'(out_last), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step();

    // addi x5, x0, -1
    send(3'd0, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_instr", out_instr, 32'hFFF0_0293);
    check("addi_err",   32'(out_err), 32'd0);
    check("addi_last",  32'(out_last), 32'd1);
    // bne x1, x2, -8 then misaligned -7
    send(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, -32'sd8);
    check("bne_instr", out_instr, 32'hFE20_9CE3);
    check("bne_err",   32'(out_err), 32'd0);
    send(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, -32'sd7);
    check("bne_odd_err", 32'(out_err), 32'd1);
    // range edges
    send(3'd0, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 32'sd2048);
    check("i_2048_err", 32'(out_err), 32'd1);
    send(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, -32'sd2049);
    check("s_m2049_err", 32'(out_err), 32'd1);
    send(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'sd4096);
    check("b_4096_err", 32'(out_err), 32'd1);
    send(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4096);
    check("b_m4096_err", 32'(out_err), 32'd0);
    send(3'd3, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 32'h0000_1001);
    check("u_low_err", 32'(out_err), 32'd1);
    send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'sd1048576);
    check("j_max_err", 32'(out_err), 32'd1);
    send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, -32'sd1048576);
    check("j_min_err", 32'(out_err), 32'd0);
    check("j_min_imm", dec_imm(3'd4, out_instr), -32'sd1048576);
    // reserved formats
    send(3'd6, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 32'hFFFF_FFFF);
    check("rsv_instr", out_instr, 32'h0000_0013);
    check("rsv_err",   32'(out_err), 32'd1);
    check("rsv_last",  32'(out_last), 32'd1);

    // li single-word cases
    send(3'd5, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'd100);
    check("li100_instr", out_instr, 32'h0640_0093);
    check("li100_last",  32'(out_last), 32'd1);
    send(3'd5, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_5000);
    check("li5000_instr", out_instr, 32'h0000_50B7);
    check("li5000_last",  32'(out_last), 32'd1);
    step();

    // two-word li under backpressure, then reset while the second word is held
    out_ready = 1'b0;
    send(3'd5, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF);
    check("li2_w1_instr", out_instr, 32'h1234_6537);
    check("li2_w1_last",  32'(out_last), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_w1_stable", out_instr, 32'h1234_6537);
      check("bp_in_ready",  32'(in_ready), 32'd0);
      check("bp_valid",     32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("li2_w2_instr", out_instr, 32'hFFF5_0513);
    check("li2_w2_last",  32'(out_last), 32'd1);
    check("li2_w2_err",   32'(out_err), 32'd0);
    out_ready = 1'b0;
    step();
    check("bp_w2_stable", out_instr, 32'hFFF5_0513);
    rst_n = 1'b0;
    step();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_instr", out_instr, 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();

    // random in-range round-trip through the decoder model
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 4000; k++) begin
        case (f)
          0, 1: imm = int'($urandom_range(0, 4095)) - 2048;
          2:    imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
          3:    begin r = int'($urandom()); imm = r & 32'hFFFF_F000; end
          default: imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        endcase
        r = int'($urandom());
        send(3'(f), 7'(r), 5'(r >> 7), 5'(r >> 12), 5'(r >> 17), 3'(r >> 22), imm);
        check("rt_imm", dec_imm(3'(f), out_instr), imm);
        check("rt_fields", out_instr & field_mask(3'(f)),
              exp_fields(3'(f), 7'(r), 5'(r >> 7), 5'(r >> 12), 5'(r >> 17), 3'(r >> 22)));
        check("rt_err",  32'(out_err), 32'd0);
        check("rt_last", 32'(out_last), 32'd1);
      end
    end

    // random range-check sweep around the limits
    for (int k = 0; k < 1500; k++) begin
      r = int'($urandom_range(0, 4));
      imm = (r == 4) ? int'($urandom_range(0, 4194303)) - 2097152
                     : int'($urandom_range(0, 16383)) - 8192;
      send(3'(r), 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, imm);
      check("rng_err", 32'(out_err), 32'(exp_err(3'(r), imm)));
    end

    // random li: execute the emitted words and compare the register value
    for (int k = 0; k < 2000; k++) begin
      r = int'($urandom_range(0, 2));
      imm = int'($urandom());
      if (r == 0) imm = int'($urandom_range(0, 4095)) - 2048;
      else if (r == 1) imm = imm & 32'hFFFF_F000;
      rd = 5'($urandom_range(1, 31));
      send(3'd5, 7'($urandom()), rd, 5'($urandom()), 5'($urandom()), 3'($urandom()), imm);
      regv = 32'hDEAD_BEEF;
      words = 0;
      for (int n = 0; n < 2; n++) begin
        w_first = out_instr;
        words++;
        check("li_rd", 32'(w_first[11:7]), 32'(rd));
        check("li_err", 32'(out_err), 32'd0);
        if (w_first[6:0] == 7'b0110111) regv = {w_first[31:12], 12'd0};
        else if (w_first[6:0] == 7'b0010011 && w_first[14:12] == 3'd0) begin
          src = (w_first[19:15] == 5'd0) ? 32'd0 : (w_first[19:15] == rd) ? regv : 32'hX;
          regv = src + {{20{w_first[31]}}, w_first[31:20]};
        end else regv = 32'hX;
        if (out_last) break;
        if (n == 0) step();
      end
      check("li_value", regv, imm);
      check("li_words", 32'(words),
            (imm >= -2048 && imm <= 2047) || ((imm & 32'hFFF) == 0) ? 32'd1 : 32'd2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
